mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported scratchpad memory port among NUM_REQ requester channels. Each channel is one mem_handle-style channel of an FPU operation block: avail, r_en, w_en, ptr, data_store, done, data_load.
- Round-robin arbitration with one access in flight at a time.
- Completion is reported as a level-held done per channel. Ops that wait on two channels at once (for example, "a.done && c.done") therefore work unchanged.
- Sits between the FPU op blocks and the memory controller.

Parameters:
- NUM_REQ, 4, number of requester channels (2..8).
- AW, 32, pointer/address width.
- DW, 32, data width.
- TIMEOUT, 64, watchdog limit in cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_avail  in  NUM_REQ  channel i has a valid request.
- req_r_en  in  NUM_REQ  read request.
- req_w_en  in  NUM_REQ  write request; wins if r_en is also high.
- req_ptr  in  NUM_REQ*AW  address, packed, channel i at [i*AW +: AW].
- req_data_store  in  NUM_REQ*DW  write data, packed.
- req_done  out  NUM_REQ  access for channel i has completed; held high while avail stays high.
- req_data_load  out  NUM_REQ*DW  per-channel read data, held until the next read completes on that channel.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_re  out  1  read strobe, held until mem_ack.
- mem_we  out  1  write strobe, held until mem_ack.
- mem_rdata  in  DW  read data, valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle acknowledge from memory.
- grant  out  NUM_REQ  one-hot; identifies the channel currently owning the port.
- arb_err  out  1  sticky watchdog error (ARB_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (async, immediate): every output is 0, state=IDLE, rr_ptr=0, completed[]=0, all data_load registers=0. A reset mid-access drops mem_re/mem_we at once and loses the access; requesters must re-issue.
- Eligibility: channel i is eligible when avail[i] is high, (r_en[i] or w_en[i]) is high, and completed[i] is 0.
- Round-robin order: the search starts at rr_ptr and wraps modulo NUM_REQ.
- State IDLE:
  - If any channel is eligible, register grant=onehot(winner), mem_addr=ptr[winner] and mem_wdata=data_store[winner].
  - Assert mem_we if w_en[winner] is high, otherwise mem_re.
  - Go to BUSY.
  - If nothing is eligible, stay in IDLE.
- State BUSY:
  - The strobe, address and data are held stable. Requester inputs are not re-sampled.
  - On mem_ack:
    - Set completed[g] (g = granted channel).
    - If the access was a read, capture mem_rdata into data_load[g].
    - Clear the strobes and grant.
    - Set rr_ptr=(g+1) mod NUM_REQ.
    - Go to IDLE.
- Timing:
  - Request visible in IDLE cycle 0; strobe asserted cycle 1.
  - With mem_ack in cycle k (k≥1), req_done[g] rises in cycle k+1.
  - Minimum spacing between accesses is 2 cycles.
- req_done[i] = completed[i] (registered output).
- completed[i] clears on the edge after avail[i] is sampled low. Requesters must drop avail for at least 1 cycle between transactions.
- If avail drops while the channel is granted and in BUSY, the access still completes. completed[i] is then set and cleared one cycle later, so done pulses for 1 cycle.
- If mem_ack arrives outside BUSY, it is ignored.
- If avail rises in the same cycle that completed[i] is cleared, the channel is eligible in the next IDLE evaluation.
- Several simultaneous requests are served in strict rotation. No channel waits more than NUM_REQ-1 other accesses.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - A counter runs in BUSY and resets on entry to BUSY.
  - If it reaches TIMEOUT without mem_ack, set arb_err (sticky until rst) and drop the strobes.
  - Set completed[g] with data_load unchanged, advance rr_ptr, and return to IDLE.
- ARB_TIMEOUT_EN not defined: no counter; BUSY waits indefinitely; arb_err is constant 0.

Test Plan:
- Single read: ch2 avail=1, r_en=1, ptr=0x10; memory acks in 3 cycles with 0xDEADBEEF. Expect mem_re and mem_addr=0x10 in cycle 1, req_done[2] rising in cycle 4, and data_load[2]=0xDEADBEEF held while avail stays high.
- Simultaneous ch0 read and ch2 write, both waiting on both dones:
  - Grant order is ch0 then ch2.
  - ch0 is not re-granted while its done is held.
  - Both dones are high together before avails drop.
  - Expect exactly 2 memory accesses.
- All 4 channels hammering with rr_ptr=1: grant order is 1,2,3,0,1… Each completion is followed by avail low for 1 cycle and then a re-request. Expect no channel to be skipped.
- r_en=1 and w_en=1 on ch1 with data_store=0x3F800000: expect mem_we=1, mem_re=0 and mem_wdata=0x3F800000.
- Assert rst during BUSY: mem_re/mem_we/grant/req_done are 0 in the same cycle. After release, a pending request is re-served from rr_ptr=0.
- With ARB_TIMEOUT_EN and TIMEOUT=8, never ack: expect arb_err=1 and the strobe dropped after 8 BUSY cycles. req_done[g]=1 and the next channel is then served.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one scratchpad port among NUM_REQ
// channels. Define ARB_TIMEOUT_EN to enable the BUSY watchdog and arb_err.
module mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_avail,
    input  logic [NUM_REQ-1:0]    req_r_en,
    input  logic [NUM_REQ-1:0]    req_w_en,
    input  logic [NUM_REQ*AW-1:0] req_ptr,
    input  logic [NUM_REQ*DW-1:0] req_data_store,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [NUM_REQ*DW-1:0] req_data_load,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic                  mem_re,
    output logic                  mem_we,
    input  logic [DW-1:0]         mem_rdata,
    input  logic                  mem_ack,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  arb_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mem_port_arbiter: unsupported parameter set");
    end

    logic [0:0]         state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      gidx;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      rr_nxt;
    logic               win_found;
    logic [NUM_REQ-1:0] completed;
    logic [NUM_REQ-1:0] eligible;
    logic               tmo;
    logic               finish;

    assign eligible = req_avail & (req_r_en | req_w_en) & ~completed;
    assign req_done = completed;
    assign rr_nxt   = (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
    assign finish   = (state == BUSY) && (mem_ack || tmo);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tcnt;

    assign tmo = (state == BUSY) && !mem_ack && (tcnt == CW'(TIMEOUT - 1));

    // Watchdog: count BUSY cycles, restart whenever the FSM sits in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt    <= '0;
            arb_err <= 1'b0;
        end else begin
            if (state == IDLE) tcnt <= '0;
            else               tcnt <= tcnt + 1'b1;
            if (tmo) arb_err <= 1'b1;
        end
    end
`else
    assign tmo     = 1'b0;
    assign arb_err = 1'b0;
`endif

    // First eligible channel at or after rr_ptr, wrapping around
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && eligible[(int'(rr_ptr) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Port FSM: latch the winner's access in IDLE, hold it until ack/timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gidx      <= '0;
            grant     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (win_found) begin
                        gidx      <= win_idx;
                        grant     <= ONE << win_idx;
                        mem_addr  <= req_ptr[win_idx*AW +: AW];
                        mem_wdata <= req_data_store[win_idx*DW +: DW];
                        mem_we    <= req_w_en[win_idx];
                        mem_re    <= !req_w_en[win_idx];
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        grant  <= '0;
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        rr_ptr <= rr_nxt;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-channel done flag and read-data capture; a finish beats avail low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            completed     <= '0;
            req_data_load <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (finish && gidx == IW'(i)) begin
                    completed[i] <= 1'b1;
                    if (mem_ack && mem_re)
                        req_data_load[i*DW +: DW] <= mem_rdata;
                end else if (!req_avail[i]) begin
                    completed[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors for mem_port_arbiter.
// Define ARB_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=8.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_avail;
    logic [N-1:0]    req_r_en;
    logic [N-1:0]    req_w_en;
    logic [N*AW-1:0] req_ptr;
    logic [N*DW-1:0] req_data_store;
    logic [N-1:0]    req_done;
    logic [N*DW-1:0] req_data_load;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_re;
    logic            mem_we;
    logic [DW-1:0]   mem_rdata;
    logic            mem_ack;
    logic [N-1:0]    grant;
    logic            arb_err;

    logic            man_ack;
    logic            auto_ack;
    logic            auto_en;
    logic [DW-1:0]   man_rdata;

    int tests = 0;
    int fails = 0;
    int order[$];

    assign mem_ack   = man_ack | auto_ack;
    assign mem_rdata = man_ack ? man_rdata : ~mem_addr;

    mem_port_arbiter #(
        .NUM_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_avail(req_avail),
        .req_r_en(req_r_en),
        .req_w_en(req_w_en),
        .req_ptr(req_ptr),
        .req_data_store(req_data_store),
        .req_done(req_done),
        .req_data_load(req_data_load),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_re(mem_re),
        .mem_we(mem_we),
        .mem_rdata(mem_rdata),
        .mem_ack(mem_ack),
        .grant(grant),
        .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic av, input logic r,
                          input logic w, input logic [31:0] p,
                          input logic [31:0] d);
        req_avail[i] = av;
        req_r_en[i]  = r;
        req_w_en[i]  = w;
        req_ptr[i*AW +: AW]        = p;
        req_data_store[i*DW +: DW] = d;
    endtask

    function automatic int oh2idx(input logic [N-1:0] g);
        int r = -1;
        for (int i = 0; i < N; i++)
            if (g[i]) r = i;
        return r;
    endfunction

    // Auto memory: acks every strobe in its first cycle, logs grant order
    always @(posedge clk) begin
        #1;
        if (auto_en && (mem_re || mem_we) && !auto_ack) begin
            auto_ack = 1'b1;
            order.push_back(oh2idx(grant));
        end else begin
            auto_ack = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        req_avail      = '0;
        req_r_en       = '0;
        req_w_en       = '0;
        req_ptr        = '0;
        req_data_store = '0;
        man_ack        = 1'b0;
        man_rdata      = '0;
        auto_en        = 1'b0;
        auto_ack       = 1'b0;

        tick;
        tick;
        chk("rst_done", req_done, 4'b0000);
        chk("rst_grant", grant, 4'b0000);
        chk("rst_re", mem_re, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_load", req_data_load, 128'h0);
        chk("rst_err", arb_err, 1'b0);
        rst = 1'b0;
        tick;

        // stray ack in IDLE must be ignored
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        chk("stray_ack_done", req_done, 4'b0000);
        chk("stray_ack_grant", grant, 4'b0000);

        // single read on ch2, ack in cycle 3
        set_ch(2, 1, 1, 0, 32'h10, 32'h0);
        tick;
        chk("t1_re", mem_re, 1'b1);
        chk("t1_we", mem_we, 1'b0);
        chk("t1_addr", mem_addr, 32'h10);
        chk("t1_grant", grant, 4'b0100);
        tick;
        chk("t1_done_c2", req_done, 4'b0000);
        tick;
        man_ack   = 1'b1;
        man_rdata = 32'hDEADBEEF;
        chk("t1_done_c3", req_done, 4'b0000);
        tick;
        man_ack = 1'b0;
        chk("t1_done_c4", req_done, 4'b0100);
        chk("t1_load", req_data_load[2*DW +: DW], 32'hDEADBEEF);
        chk("t1_re_off", mem_re, 1'b0);
        chk("t1_grant_off", grant, 4'b0000);
        tick;
        tick;
        chk("t1_done_held", req_done, 4'b0100);
        chk("t1_load_held", req_data_load[2*DW +: DW], 32'hDEADBEEF);
        set_ch(2, 0, 0, 0, 32'h10, 32'h0);
        tick;
        chk("t1_done_clr", req_done, 4'b0000);
        chk("t1_load_keep", req_data_load[2*DW +: DW], 32'hDEADBEEF);

        // ch0 read + ch2 write, both held until both done (rr_ptr=3)
        order.delete();
        auto_en = 1'b1;
        set_ch(0, 1, 1, 0, 32'h20, 32'h0);
        set_ch(2, 1, 0, 1, 32'h24, 32'h1234);
        for (int c = 0; c < 20 && req_done != 4'b0101; c++) tick;
        chk("t2_both_done", req_done, 4'b0101);
        tick;
        tick;
        tick;
        chk("t2_accesses", order.size(), 2);
        chk("t2_first", (order.size() > 0) ? order[0] : -1, 0);
        chk("t2_second", (order.size() > 1) ? order[1] : -1, 2);
        chk("t2_load0", req_data_load[0 +: DW], 32'hFFFFFFDF);
        chk("t2_load2", req_data_load[2*DW +: DW], 32'hDEADBEEF);
        set_ch(0, 0, 0, 0, 32'h0, 32'h0);
        set_ch(2, 0, 0, 0, 32'h0, 32'h0);
        tick;
        chk("t2_done_clr", req_done, 4'b0000);
        auto_en = 1'b0;

        // r_en and w_en together on ch1: write wins
        set_ch(1, 1, 1, 1, 32'h30, 32'h3F800000);
        tick;
        chk("t4_we", mem_we, 1'b1);
        chk("t4_re", mem_re, 1'b0);
        chk("t4_wdata", mem_wdata, 32'h3F800000);
        chk("t4_grant", grant, 4'b0010);
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        chk("t4_done", req_done, 4'b0010);
        chk("t4_load1", req_data_load[DW +: DW], 32'h0);
        set_ch(1, 0, 0, 0, 32'h0, 32'h0);
        tick;

        // reset during BUSY, then re-serve from rr_ptr=0
        set_ch(3, 1, 1, 0, 32'h40, 32'h0);
        tick;
        chk("t5_busy_grant", grant, 4'b1000);
        set_ch(1, 1, 1, 0, 32'h44, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_re", mem_re, 1'b0);
        chk("t5_rst_we", mem_we, 1'b0);
        chk("t5_rst_grant", grant, 4'b0000);
        chk("t5_rst_done", req_done, 4'b0000);
        #1;
        rst = 1'b0;
        tick;
        chk("t5_regrant", grant, 4'b0010);
        chk("t5_addr", mem_addr, 32'h44);
        man_ack   = 1'b1;
        man_rdata = 32'hCAFE0001;
        tick;
        man_ack = 1'b0;
        chk("t5_done1", req_done, 4'b0010);
        chk("t5_load1", req_data_load[DW +: DW], 32'hCAFE0001);
        tick;
        chk("t5_next", grant, 4'b1000);
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        chk("t5_done13", req_done, 4'b1010);
        set_ch(1, 0, 0, 0, 32'h0, 32'h0);
        set_ch(3, 0, 0, 0, 32'h0, 32'h0);
        tick;

        // one ch0 access to move rr_ptr to 1
        set_ch(0, 1, 1, 0, 32'h50, 32'h0);
        tick;
        chk("t3_pre_grant", grant, 4'b0001);
        man_ack = 1'b1;
        tick;
        man_ack = 1'b0;
        set_ch(0, 0, 0, 0, 32'h0, 32'h0);
        tick;

        // all channels hammering with drop-and-re-request
        order.delete();
        auto_en = 1'b1;
        for (int i = 0; i < N; i++)
            set_ch(i, 1, 1, 0, 32'h100 + 32'(i * 4), 32'h0);
        for (int c = 0; c < 80 && order.size() < 12; c++) begin
            tick;
            for (int i = 0; i < N; i++) begin
                if (req_done[i] && req_avail[i]) req_avail[i] = 1'b0;
                else if (!req_avail[i])          req_avail[i] = 1'b1;
            end
        end
        chk("t3_count", order.size(), 12);
        for (int k = 0; k < 12; k++)
            chk($sformatf("t3_order%0d", k),
                (order.size() > k) ? order[k] : -1, (1 + k) % 4);
        req_avail = '0;
        tick;
        tick;
        tick;
        tick;
        auto_en = 1'b0;
        tick;
        chk("t3_idle", grant, 4'b0000);
        chk("t3_err", arb_err, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // watchdog: never ack ch0, expect timeout after 8 BUSY cycles
        rst = 1'b1;
        #2;
        rst = 1'b0;
        set_ch(0, 1, 1, 0, 32'h60, 32'h0);
        set_ch(1, 1, 1, 0, 32'h64, 32'h0);
        tick;
        chk("t6_grant", grant, 4'b0001);
        for (int c = 0; c < 7; c++) tick;
        chk("t6_re_c8", mem_re, 1'b1);
        chk("t6_err_c8", arb_err, 1'b0);
        tick;
        chk("t6_re_drop", mem_re, 1'b0);
        chk("t6_err", arb_err, 1'b1);
        chk("t6_done0", req_done, 4'b0001);
        chk("t6_load0", req_data_load[0 +: DW], 32'h0);
        tick;
        chk("t6_next", grant, 4'b0010);
        chk("t6_next_re", mem_re, 1'b1);
        man_ack   = 1'b1;
        man_rdata = 32'h0BADF00D;
        tick;
        man_ack = 1'b0;
        chk("t6_done01", req_done, 4'b0011);
        chk("t6_err_sticky", arb_err, 1'b1);
        req_avail = '0;
        tick;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
